// File: rtl/light_part_evict_rx_if.sv
// Evicted-entry input and light-part update bundle
// between the heavy-part table and the light-part receiver.
interface light_part_evict_rx_if #(
    parameter int CNT_W = 8
);
    logic             ip_addr_value_in_wr;
    logic [95:0]      ip_addr_value_in;
    logic             ip_addr_value_in_alf;
    logic             light_upd_wr;
    logic [11:0]      light_upd_index;
    logic [CNT_W-1:0] light_upd_value;
    logic [15:0]      drop_cnt;

    modport master (
        output ip_addr_value_in_wr,
        output ip_addr_value_in,
        input  ip_addr_value_in_alf,
        input  light_upd_wr,
        input  light_upd_index,
        input  light_upd_value,
        input  drop_cnt
    );

    modport slave (
        input  ip_addr_value_in_wr,
        input  ip_addr_value_in,
        output ip_addr_value_in_alf,
        output light_upd_wr,
        output light_upd_index,
        output light_upd_value,
        output drop_cnt
    );
endinterface

// File: rtl/light_part_evict_rx.sv
// Buffers evicted heavy-part entries and folds their counts
// into a 4096-entry saturating light-part counter table.
module light_part_evict_rx #(
    parameter int FIFO_DEPTH = 16,
    parameter int ALF_LEVEL  = 12,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    light_part_evict_rx_if.slave bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] ALF_THR = (AW+1)'(ALF_LEVEL);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        RD,
        WT,
        WR
    } state_t;

    state_t state, state_nxt;

    logic [63:0]      fifo_mem [FIFO_DEPTH];
    logic [CNT_W-1:0] ram [4096];

    logic [AW:0]      wptr, rptr, occ, occ_nxt;
    logic             empty, full, push, pop;
    logic [63:0]      head;
    logic [31:0]      head_ip, head_cnt;
    logic [11:0]      head_idx;
    logic [CNT_W-1:0] head_cnt_sat;

    logic [11:0]      clr_addr, cur_idx;
    logic [CNT_W-1:0] cur_cnt, old_val, new_val, ram_q;
    logic [CNT_W:0]   sum;
    logic             ram_we, ram_re;
    logic [11:0]      ram_waddr;
    logic [CNT_W-1:0] ram_wdata;

    logic             alf_q, upd_wr_q;
    logic [11:0]      upd_idx_q;
    logic [CNT_W-1:0] upd_val_q;
    logic [15:0]      drop_q;
    logic             unused_low;

    assign unused_low = ^bus.ip_addr_value_in[31:0];

    assign bus.ip_addr_value_in_alf = alf_q;
    assign bus.light_upd_wr         = upd_wr_q;
    assign bus.light_upd_index      = upd_idx_q;
    assign bus.light_upd_value      = upd_val_q;
    assign bus.drop_cnt             = drop_q;

    // Extra pointer bit separates full from empty.
    assign occ   = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push  = bus.ip_addr_value_in_wr && (!full || pop);

    assign head     = fifo_mem[rptr[AW-1:0]];
    assign head_ip  = head[63:32];
    assign head_cnt = head[31:0];
    assign head_idx = head_ip[11:0] ^ head_ip[23:12] ^
                      {4'b0, head_ip[31:24]};
    assign head_cnt_sat = (|head_cnt[31:CNT_W]) ?
                          CNT_MAX : head_cnt[CNT_W-1:0];

    assign sum     = {1'b0, old_val} + {1'b0, cur_cnt};
    assign new_val = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];

    always_comb begin
        occ_nxt = occ;
        if (push && !pop) begin
            occ_nxt = occ + 1'b1;
        end else if (pop && !push) begin
            occ_nxt = occ - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = cur_idx;
        ram_wdata = new_val;
        unique case (state)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr;
                ram_wdata = '0;
                if (clr_addr == 12'hFFF) state_nxt = IDLE;
            end
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    // Zero-count entries are consumed without a RAM access.
                    if (head_cnt != 32'd0) state_nxt = RD;
                end
            end
            RD: begin
                ram_re    = 1'b1;
                state_nxt = WT;
            end
            WT: state_nxt = WR;
            WR: begin
                ram_we    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            wptr      <= '0;
            rptr      <= '0;
            cur_idx   <= '0;
            cur_cnt   <= '0;
            old_val   <= '0;
            alf_q     <= 1'b1;
            upd_wr_q  <= 1'b0;
            upd_idx_q <= '0;
            upd_val_q <= '0;
            drop_q    <= '0;
        end else begin
            state    <= state_nxt;
            alf_q    <= (occ_nxt >= ALF_THR) || (state_nxt == CLEAR);
            upd_wr_q <= 1'b0;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (bus.ip_addr_value_in_wr && !push && drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
            if (state == CLEAR) clr_addr <= clr_addr + 12'd1;
            if (pop) begin
                cur_idx <= head_idx;
                cur_cnt <= head_cnt_sat;
            end
            if (state == WT) old_val <= ram_q;
            if (state == WR) begin
                upd_wr_q  <= 1'b1;
                upd_idx_q <= cur_idx;
                upd_val_q <= new_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr[AW-1:0]] <= bus.ip_addr_value_in[95:32];
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
        if (ram_re) ram_q <= ram[cur_idx];
    end

endmodule

// File: tb/tb_light_part_evict_rx.sv
// Randomized self-checking bench for light_part_evict_rx
// against a table-and-queue reference model.
module tb_light_part_evict_rx;

    localparam int CW = 8;
    localparam int unsigned MAXV = (1 << CW) - 1;

    typedef struct {
        logic [11:0]   idx;
        logic [CW-1:0] val;
        int            cyc;
    } upd_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   exp_drop = 0;

    int unsigned model_ram [4096];
    upd_t exp_q [$];
    upd_t obs_q [$];

    light_part_evict_rx_if #(.CNT_W(CW)) bus ();

    light_part_evict_rx #(
        .FIFO_DEPTH(16),
        .ALF_LEVEL (12),
        .CNT_W     (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.light_upd_wr === 1'b1)
            obs_q.push_back('{bus.light_upd_index, bus.light_upd_value, cyc});
    end

    function automatic logic [11:0] idx_of(input logic [31:0] ip);
        return ip[11:0] ^ ip[23:12] ^ {4'h0, ip[31:24]};
    endfunction

    task automatic model_clear();
        foreach (model_ram[i]) model_ram[i] = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic model_accept(input logic [31:0] ip, input logic [31:0] cnt);
        logic [11:0] i;
        int unsigned add, v;
        if (cnt == 32'd0) return;
        i   = idx_of(ip);
        add = (cnt > MAXV) ? MAXV : cnt;
        v   = model_ram[i] + add;
        if (v > MAXV) v = MAXV;
        model_ram[i] = v;
        exp_q.push_back('{i, v[CW-1:0], 0});
    endtask

    task automatic send(input logic [31:0] ip, input logic [31:0] cnt,
                        output int acc);
        bus.ip_addr_value_in_wr = 1'b1;
        bus.ip_addr_value_in    = {ip, cnt, 32'($urandom())};
        @(negedge clk);
        acc = cyc;
        bus.ip_addr_value_in_wr = 1'b0;
    endtask

    task automatic wait_updates(input int n, input int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (obs_q.size() < n) begin
            bad++;
            $display("FAIL wait_updates: got %0d updates, required %0d",
                     obs_q.size(), n);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        exp_drop = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total += 5;
        if (bus.ip_addr_value_in_alf !== 1'b1) begin
            bad++; $display("FAIL rst_alf: got %b, required 1", bus.ip_addr_value_in_alf);
        end
        if (bus.light_upd_wr !== 1'b0) begin
            bad++; $display("FAIL rst_wr: got %b, required 0", bus.light_upd_wr);
        end
        if (bus.light_upd_index !== 12'h000) begin
            bad++; $display("FAIL rst_idx: got %h, required 000", bus.light_upd_index);
        end
        if (bus.light_upd_value !== '0) begin
            bad++; $display("FAIL rst_val: got %0d, required 0", bus.light_upd_value);
        end
        if (bus.drop_cnt !== 16'd0) begin
            bad++; $display("FAIL rst_drop: got %0d, required 0", bus.drop_cnt);
        end
    endtask

    task automatic check_clear_window(input string name);
        int hi_bad = 0;
        for (int i = 0; i < 4095; i++) begin
            @(negedge clk);
            if (bus.ip_addr_value_in_alf !== 1'b1) hi_bad++;
        end
        total++;
        if (hi_bad != 0) begin
            bad++;
            $display("FAIL %s_alf_hi: got %0d low cycles, required 0", name, hi_bad);
        end
        @(negedge clk);
        total++;
        if (bus.ip_addr_value_in_alf !== 1'b0) begin
            bad++;
            $display("FAIL %s_alf_lo: got %b, required 0", name, bus.ip_addr_value_in_alf);
        end
    endtask

    task automatic test_clear();
        logic [31:0] ip, cnt;
        int a;
        release_reset();
        check_clear_window("clear");
        do ip = $urandom(); while (idx_of(ip) == 12'h00B);
        cnt = 32'($urandom_range(1, 255));
        send(ip, cnt, a);
        model_accept(ip, cnt);
        wait_updates(1, 20);
        total++;
        if (obs_q.size() > 0 && obs_q[0].val !== cnt[CW-1:0]) begin
            bad++;
            $display("FAIL clear_old0: got %0d, required %0d", obs_q[0].val, cnt);
        end
    endtask

    task automatic test_single();
        int a;
        for (int r = 0; r < 2; r++) begin
            obs_q.delete(); exp_q.delete();
            send(32'h0A000001, 32'd5, a);
            model_accept(32'h0A000001, 32'd5);
            wait_updates(1, 20);
            if (obs_q.size() > 0) begin
                total += 3;
                if (obs_q[0].idx !== 12'h00B) begin
                    bad++; $display("FAIL single_idx: got %h, required 00B", obs_q[0].idx);
                end
                if (obs_q[0].val !== exp_q[0].val) begin
                    bad++; $display("FAIL single_val: got %0d, required %0d",
                                    obs_q[0].val, exp_q[0].val);
                end
                if (obs_q[0].cyc - a != 4) begin
                    bad++; $display("FAIL single_lat: got %0d, required 4", obs_q[0].cyc - a);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int a;
        logic [31:0] cnts [2];
        cnts[0] = 32'd300;
        cnts[1] = 32'd1;
        for (int r = 0; r < 2; r++) begin
            obs_q.delete(); exp_q.delete();
            send(32'h00000123, cnts[r], a);
            model_accept(32'h00000123, cnts[r]);
            wait_updates(1, 20);
            total++;
            if (obs_q.size() > 0 && obs_q[0].val !== exp_q[0].val) begin
                bad++; $display("FAIL sat_val%0d: got %0d, required %0d",
                                r, obs_q[0].val, exp_q[0].val);
            end
        end
    endtask

    task automatic test_zero_count();
        logic [31:0] ip;
        int a;
        obs_q.delete(); exp_q.delete();
        ip = $urandom();
        send(ip, 32'd0, a);
        model_accept(ip, 32'd0);
        repeat (12) @(negedge clk);
        total++;
        if (obs_q.size() != 0) begin
            bad++; $display("FAIL zero_nowr: got %0d updates, required 0", obs_q.size());
        end
        send(ip, 32'd3, a);
        model_accept(ip, 32'd3);
        wait_updates(1, 20);
        if (obs_q.size() > 0) begin
            total += 2;
            if (obs_q[0].val !== exp_q[0].val) begin
                bad++; $display("FAIL zero_follow_val: got %0d, required %0d",
                                obs_q[0].val, exp_q[0].val);
            end
            if (obs_q[0].cyc - a != 4) begin
                bad++; $display("FAIL zero_follow_lat: got %0d, required 4", obs_q[0].cyc - a);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ip, cnt;
        int a, a0, gap_bad, mis;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            ip  = $urandom();
            cnt = 32'($urandom_range(1, 255));
            send(ip, cnt, a);
            if (i == 0) a0 = a;
            model_accept(ip, cnt);
        end
        total++;
        if (bus.ip_addr_value_in_alf !== 1'b1) begin
            bad++; $display("FAIL b2b_alf: got %b, required 1", bus.ip_addr_value_in_alf);
        end
        wait_updates(16, 120);
        mis = 0; gap_bad = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if (obs_q[i].idx !== exp_q[i].idx || obs_q[i].val !== exp_q[i].val) mis++;
            if (i > 0 && obs_q[i].cyc - obs_q[i-1].cyc != 4) gap_bad++;
        end
        total += 3;
        if (mis != 0) begin
            bad++; $display("FAIL b2b_data: got %0d wrong updates, required 0", mis);
        end
        if (gap_bad != 0) begin
            bad++; $display("FAIL b2b_spacing: got %0d bad gaps, required 0", gap_bad);
        end
        if (obs_q.size() > 0 && obs_q[0].cyc - a0 != 4) begin
            bad++; $display("FAIL b2b_lat: got %0d, required 4", obs_q[0].cyc - a0);
        end
        repeat (4) @(negedge clk);
        total += 2;
        if (bus.ip_addr_value_in_alf !== 1'b0) begin
            bad++; $display("FAIL b2b_alf_drain: got %b, required 0", bus.ip_addr_value_in_alf);
        end
        if (bus.drop_cnt !== 16'(exp_drop)) begin
            bad++; $display("FAIL b2b_drop: got %0d, required %0d", bus.drop_cnt, exp_drop);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ip, cnt;
        int a, mis, gap_bad;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        release_reset();
        for (int i = 0; i < 20; i++) begin
            ip  = $urandom();
            cnt = 32'($urandom_range(1, 255));
            send(ip, cnt, a);
            if (i < 16) model_accept(ip, cnt);
            else exp_drop++;
        end
        total += 2;
        if (bus.ip_addr_value_in_alf !== 1'b1) begin
            bad++; $display("FAIL bp_alf: got %b, required 1", bus.ip_addr_value_in_alf);
        end
        if (bus.drop_cnt !== 16'(exp_drop)) begin
            bad++; $display("FAIL bp_drop: got %0d, required %0d", bus.drop_cnt, exp_drop);
        end
        // Land a push on the first pop edge while the FIFO is full.
        repeat (4096 - 20) @(negedge clk);
        ip  = $urandom();
        cnt = 32'($urandom_range(1, 255));
        send(ip, cnt, a);
        model_accept(ip, cnt);
        wait_updates(17, 120);
        mis = 0; gap_bad = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if (obs_q[i].idx !== exp_q[i].idx || obs_q[i].val !== exp_q[i].val) mis++;
            if (i > 0 && obs_q[i].cyc - obs_q[i-1].cyc != 4) gap_bad++;
        end
        total += 3;
        if (mis != 0) begin
            bad++; $display("FAIL bp_data: got %0d wrong updates, required 0", mis);
        end
        if (gap_bad != 0) begin
            bad++; $display("FAIL bp_spacing: got %0d bad gaps, required 0", gap_bad);
        end
        if (bus.drop_cnt !== 16'(exp_drop)) begin
            bad++; $display("FAIL bp_drop_full_pop: got %0d, required %0d",
                            bus.drop_cnt, exp_drop);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] ip;
        int a;
        obs_q.delete(); exp_q.delete();
        ip = $urandom();
        send(ip, 32'd50, a);
        model_accept(ip, 32'd50);
        wait_updates(1, 20);
        repeat (2) @(negedge clk);
        obs_q.delete();
        send(ip, 32'd9, a);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        total += 5;
        if (bus.light_upd_wr !== 1'b0) begin
            bad++; $display("FAIL mid_wr: got %b, required 0", bus.light_upd_wr);
        end
        if (bus.light_upd_index !== 12'h000) begin
            bad++; $display("FAIL mid_idx: got %h, required 000", bus.light_upd_index);
        end
        if (bus.light_upd_value !== '0) begin
            bad++; $display("FAIL mid_val: got %0d, required 0", bus.light_upd_value);
        end
        if (bus.ip_addr_value_in_alf !== 1'b1) begin
            bad++; $display("FAIL mid_alf: got %b, required 1", bus.ip_addr_value_in_alf);
        end
        if (bus.drop_cnt !== 16'd0) begin
            bad++; $display("FAIL mid_drop: got %0d, required 0", bus.drop_cnt);
        end
        repeat (2) @(negedge clk);
        release_reset();
        check_clear_window("mid");
        total++;
        if (obs_q.size() != 0) begin
            bad++; $display("FAIL mid_abandon: got %0d updates, required 0", obs_q.size());
        end
        send(ip, 32'd4, a);
        model_accept(ip, 32'd4);
        wait_updates(1, 20);
        total++;
        if (obs_q.size() > 0 && obs_q[0].val !== exp_q[0].val) begin
            bad++; $display("FAIL mid_recleared: got %0d, required %0d",
                            obs_q[0].val, exp_q[0].val);
        end
    endtask

    task automatic test_random();
        logic [31:0] ip, cnt;
        int a, len, mis;
        obs_q.delete(); exp_q.delete();
        for (int b = 0; b < 12; b++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                ip = ($urandom_range(0, 1) == 0) ?
                     32'($urandom_range(0, 7)) : 32'($urandom());
                case ($urandom_range(0, 3))
                    0:       cnt = 32'd0;
                    1:       cnt = 32'($urandom_range(1, 40));
                    2:       cnt = 32'($urandom_range(200, 400));
                    default: cnt = 32'($urandom());
                endcase
                send(ip, cnt, a);
                model_accept(ip, cnt);
            end
            repeat (30) @(negedge clk);
        end
        wait_updates(exp_q.size(), 100);
        mis = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if (obs_q[i].idx !== exp_q[i].idx || obs_q[i].val !== exp_q[i].val) mis++;
        end
        total += 3;
        if (mis != 0) begin
            bad++; $display("FAIL rand_data: got %0d wrong updates, required 0", mis);
        end
        if (obs_q.size() != exp_q.size()) begin
            bad++; $display("FAIL rand_count: got %0d updates, required %0d",
                            obs_q.size(), exp_q.size());
        end
        if (bus.drop_cnt !== 16'(exp_drop)) begin
            bad++; $display("FAIL rand_drop: got %0d, required %0d", bus.drop_cnt, exp_drop);
        end
    endtask

    initial begin
        bus.ip_addr_value_in_wr = 1'b0;
        bus.ip_addr_value_in    = '0;
        test_reset();
        test_clear();
        test_single();
        test_saturation();
        test_zero_count();
        test_back_to_back();
        test_random();
        test_backpressure();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/light_part_evict_rx.md
LIGHT_PART_EVICT_RX -- requirements
Module: light_part_evict_rx

Interface
REQ-001 The block SHALL have the parameter FIFO_DEPTH, default 16, meaning the number of entries in the input FIFO (power of two).
REQ-002 The block SHALL have the parameter ALF_LEVEL, default 12, meaning the FIFO occupancy at or above which ip_addr_value_in_alf is asserted.
REQ-003 The block SHALL have the parameter CNT_W, default 8, meaning the width of a light-part counter.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have the port ip_addr_value_in_wr, input, 1 bit: the evicted-entry write strobe.
REQ-007 The block SHALL have the port ip_addr_value_in, input, 96 bits: the entry; [95:64] holds the IP, [63:32] the count, and [31:0] is ignored.
REQ-008 The block SHALL have the port ip_addr_value_in_alf, output, 1 bit: the almost-full backpressure signal to the heavy-part table.
REQ-009 The block SHALL have the port light_upd_wr, output, 1 bit: a one-cycle pulse per counter update.
REQ-010 The block SHALL have the port light_upd_index, output, 12 bits: the updated counter index.
REQ-011 The block SHALL have the port light_upd_value, output, CNT_W bits: the new counter value.
REQ-012 The block SHALL have the port drop_cnt, output, 16 bits: the number of entries dropped on a full FIFO.

Function
REQ-013 On a rising edge with ip_addr_value_in_wr=1 and the FIFO not full, the block SHALL write the entry to the FIFO.
REQ-014 On a rising edge with ip_addr_value_in_wr=1 and the FIFO full, the block SHALL discard the entry and increment drop_cnt, saturating at 16'hFFFF.
REQ-015 The block SHALL register ip_addr_value_in_alf as (occupancy >= ALF_LEVEL) OR (state == CLEAR), so it reflects the occupancy after the current edge.
REQ-016 The block SHALL hold the light part in internal dual-port RAM of 4096 x CNT_W bits with a 1-cycle read latency.
REQ-017 The counter index SHALL be ip[11:0] ^ ip[23:12] ^ {4'b0, ip[31:24]}.
REQ-018 The FSM SHALL have the states CLEAR, IDLE, RD, WT and WR.
REQ-019 In CLEAR, the block SHALL write 0 to one RAM address per cycle, from 0 to 4095, then move to IDLE; FIFO writes SHALL still be accepted during CLEAR.
REQ-020 In IDLE with the FIFO non-empty, the block SHALL pop the head entry, latch the IP, count and index, and move to RD.
REQ-021 In IDLE with a popped count of 0, the block SHALL make no RAM access, produce no light_upd_wr, and stay in IDLE.
REQ-022 In RD, the block SHALL issue a RAM read at the index and move to WT.
REQ-023 In WT, the block SHALL capture the RAM data and move to WR.
REQ-024 In WR, the block SHALL write the new value = min(old + min(count, 2^CNT_W-1), 2^CNT_W-1), pulse light_upd_wr with index and value, and move to IDLE.
REQ-025 Throughput SHALL be one entry per 4 cycles.
REQ-026 With the FIFO empty and the FSM in IDLE, light_upd_wr SHALL assert on the 4th rising edge after the accepting edge.
REQ-027 On a simultaneous push and pop, occupancy SHALL be unchanged and both operations SHALL take effect.
REQ-028 On a push while the FIFO is full and a pop occurs on the same edge, the push SHALL be accepted and not dropped.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and full/empty SHALL be distinguished by an extra pointer bit.
REQ-030 Because processing is serial, the read of entry N+1 SHALL occur after the write of entry N, and SHALL observe that write.

Reset
REQ-031 Reset assertion SHALL take effect immediately, regardless of clk.
REQ-032 During reset: FIFO empty, drop_cnt=0, light_upd_wr=0, light_upd_index=0, light_upd_value=0, ip_addr_value_in_alf=1, state=CLEAR with clear address 0.
REQ-033 A reset asserted mid-operation SHALL abandon any in-flight entry and restart the full 4096-cycle CLEAR after release.

Verification
REQ-034 Bench scenario (clear): release reset and hold wr=0 -> alf=1 for 4096 cycles, then 0; a subsequent update to any index returns old=0.
REQ-035 Bench scenario (single update): IP=32'h0A000001, count=5 -> index 12'h00B (001 ^ 000 ^ 00A); light_upd_wr 4 edges after acceptance with value 5; a repeat gives 10.
REQ-036 Bench scenario (saturation): count=300 on a fresh index -> value 255; a further count=1 -> value 255.
REQ-037 Bench scenario (backpressure/drop): 20 back-to-back writes during CLEAR -> alf=1, 16 accepted, drop_cnt=4; after CLEAR, 16 updates in order at 4-cycle spacing.
REQ-038 Bench scenario (zero count and reset mid-flight): count=0 -> no light_upd_wr; reset asserted in WT -> outputs 0 at once, CLEAR restarts, no light_upd_wr for that entry.
